// File: rtl/dptr_bank_pkg.sv
// dptr_bank shared definitions.
// SFR addresses, DPS bit positions and the DPS register layout.
package dptr_bank_pkg;

  localparam logic [7:0] SFR_DPTR_LO = 8'h82;
  localparam logic [7:0] SFR_DPTR_HI = 8'h83;
  localparam logic [7:0] SFR_DPS     = 8'h86;

  localparam int DPS_AUTO = 7;
  localparam int DPS_DIR  = 6;
  localparam int DPS_TSL  = 5;

  typedef struct packed {
    logic       auto_inc;
    logic       dir;
    logic       tsl;
    logic [1:0] sel;
  } dps_t;

  function automatic logic [7:0] dps_pack(input dps_t d);
    return {d.auto_inc, d.dir, d.tsl, 3'b000, d.sel};
  endfunction

endpackage

// File: rtl/dptr_step.sv
// 16-bit +1/-1 with carry/borrow rippled from low byte into high byte.
// Wraps at both ends; no flags.
module dptr_step (
  input  logic [15:0] val_i,
  input  logic        dec_i,
  output logic [15:0] res_o
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       cy;

  always_comb begin
    cy = dec_i ? (val_i[7:0] == 8'h00)
               : (val_i[7:0] == 8'hFF);
    lo = dec_i ? val_i[7:0] - 8'd1
               : val_i[7:0] + 8'd1;
    hi = val_i[15:8];
    if (cy) begin
      hi = dec_i ? val_i[15:8] - 8'd1
                 : val_i[15:8] + 8'd1;
    end
    res_o = {hi, lo};
  end

endmodule

// File: rtl/dptr_bank.sv
// Bank of NUM_DPTR data pointers with DPS select/mode SFR.
// The active pointer drives dptr; one pointer action per cycle.
module dptr_bank
  import dptr_bank_pkg::*;
#(
  parameter int         NUM_DPTR = 2,
  parameter logic [7:0] ADDR_DPL = SFR_DPTR_LO,
  parameter logic [7:0] ADDR_DPH = SFR_DPTR_HI,
  parameter logic [7:0] ADDR_DPS = SFR_DPS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  sfr_addr,
  input  logic        sfr_wr,
  input  logic [7:0]  sfr_wdata,
  output logic [7:0]  sfr_rdata,
  output logic        sfr_hit,
  input  logic        ld16,
  input  logic [15:0] ld_data,
  input  logic        inc,
  input  logic        movx_done,
  output logic [15:0] dptr,
  output logic [7:0]  dps
);

  localparam logic [1:0] SEL_MAX = 2'(NUM_DPTR - 1);
  localparam logic [2:0] NUM3    = 3'(NUM_DPTR);

  logic [15:0] ptr_q [NUM_DPTR];
  logic [15:0] ptr_d [NUM_DPTR];
  dps_t        dps_q;
  dps_t        dps_d;

  logic [15:0] cur;
  logic [15:0] step_val;
  logic [15:0] new_val;
  logic        ptr_we;
  logic        step_dec;
  logic        dpl_wr;
  logic        dph_wr;
  logic        dps_wr;
  logic [1:0]  sel_nx;

  assign dpl_wr = sfr_wr && (sfr_addr == ADDR_DPL);
  assign dph_wr = sfr_wr && (sfr_addr == ADDR_DPH);
  assign dps_wr = sfr_wr && (sfr_addr == ADDR_DPS);

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_DPTR; i++) begin
      if (dps_q.sel == 2'(i)) cur = ptr_q[i];
    end
  end

  // INC DPTR always counts up; only MOVX auto-step honours DIR
  assign step_dec = inc ? 1'b0 : dps_q.dir;

  dptr_step u_step (
    .val_i (cur),
    .dec_i (step_dec),
    .res_o (step_val)
  );

  always_comb begin
    ptr_we  = 1'b1;
    new_val = cur;
    if (ld16) begin
      new_val = ld_data;
    end else if (dpl_wr) begin
      new_val = {cur[15:8], sfr_wdata};
    end else if (dph_wr) begin
      new_val = {sfr_wdata, cur[7:0]};
    end else if (inc || (movx_done && dps_q.auto_inc)) begin
      new_val = step_val;
    end else begin
      ptr_we = 1'b0;
    end
    for (int i = 0; i < NUM_DPTR; i++) begin
      ptr_d[i] = (ptr_we && dps_q.sel == 2'(i))
               ? new_val : ptr_q[i];
    end
  end

  assign sel_nx = (dps_q.sel == SEL_MAX) ? 2'd0
                : dps_q.sel + 2'd1;

  always_comb begin
    dps_d = dps_q;
    if (dps_wr) begin
      dps_d.auto_inc = sfr_wdata[DPS_AUTO];
      dps_d.dir      = sfr_wdata[DPS_DIR];
      dps_d.tsl      = sfr_wdata[DPS_TSL];
      if ({1'b0, sfr_wdata[1:0]} < NUM3) begin
        dps_d.sel = sfr_wdata[1:0];
      end
    end else if (movx_done && dps_q.tsl) begin
      dps_d.sel = sel_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DPTR; i++) begin
        ptr_q[i] <= '0;
      end
      dps_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DPTR; i++) begin
        ptr_q[i] <= ptr_d[i];
      end
      dps_q <= dps_d;
    end
  end

  assign dptr = cur;
  assign dps  = dps_pack(dps_q);

  assign sfr_hit = (sfr_addr == ADDR_DPL)
                || (sfr_addr == ADDR_DPH)
                || (sfr_addr == ADDR_DPS);

  always_comb begin
    sfr_rdata = '0;
    if (sfr_addr == ADDR_DPL) begin
      sfr_rdata = cur[7:0];
    end else if (sfr_addr == ADDR_DPH) begin
      sfr_rdata = cur[15:8];
    end else if (sfr_addr == ADDR_DPS) begin
      sfr_rdata = dps_pack(dps_q);
    end
  end

endmodule
